// File: rtl/rx_word_packer_if.sv
// Byte-in / word-out bus between the UART receiver, the packer and the core loader.
// The master side is the packer: it drives the word and its valid.
interface rx_word_packer_if;
    logic [7:0]  in_data;
    logic        in_valid;
    logic [31:0] word;
    logic        word_valid;
    logic        word_ready;

    modport master (
        input  in_data,
        input  in_valid,
        input  word_ready,
        output word,
        output word_valid
    );

    modport slave (
        output in_data,
        output in_valid,
        output word_ready,
        input  word,
        input  word_valid
    );
endinterface

// File: rtl/rx_word_packer.sv
// Buffers receiver bytes in a FIFO and packs them into big-endian 32-bit words.
// The receiver cannot be stalled, so bytes arriving at a full FIFO are dropped and flagged.
module rx_word_packer #(
    parameter int unsigned DEPTH      = 16,
    parameter int unsigned ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clear,
    rx_word_packer_if.master      bus,
    output logic                  overflow,
    output logic [ADDR_WIDTH:0]   level
);

    localparam int unsigned LVL_W = ADDR_WIDTH + 1;

    typedef enum logic {
        COLLECT = 1'b0,
        HOLD    = 1'b1
    } state_e;

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   rd_ptr_q, rd_ptr_d;
    logic [ADDR_WIDTH-1:0]   wr_ptr_q, wr_ptr_d;
    logic [LVL_W-1:0]        level_q, level_d;
    logic [1:0]              idx_q, idx_d;
    logic [31:0]             word_q, word_d;
    logic                    word_valid_q, word_valid_d;
    logic                    overflow_q, overflow_d;

    logic [7:0]              mem_q [DEPTH];
    logic [7:0]              head_byte;
    logic                    full_c;
    logic                    push_c;
    logic                    pop_c;

    // Next-state: FSM pops into the word, FIFO bookkeeping, then clear overrides.
    always_comb begin
        state_d      = state_q;
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        level_d      = level_q;
        idx_d        = idx_q;
        word_d       = word_q;
        word_valid_d = word_valid_q;
        overflow_d   = overflow_q;
        pop_c        = 1'b0;
        push_c       = 1'b0;
        full_c       = (level_q == LVL_W'(DEPTH));
        head_byte    = mem_q[rd_ptr_q];

        case (state_q)
            COLLECT: begin
                pop_c = (level_q != '0) && !clear;
                if (pop_c) begin
                    case (idx_q)
                        2'd0:    word_d[31:24] = head_byte;
                        2'd1:    word_d[23:16] = head_byte;
                        2'd2:    word_d[15:8]  = head_byte;
                        default: word_d[7:0]   = head_byte;
                    endcase
                    idx_d = idx_q + 2'd1;
                    if (idx_q == 2'd3) begin
                        state_d      = HOLD;
                        word_valid_d = 1'b1;
                    end
                end
            end
            HOLD: begin
                // Acceptance cycle never pops; collection resumes on the next cycle.
                if (bus.word_ready) begin
                    word_valid_d = 1'b0;
                    state_d      = COLLECT;
                end
            end
            default: state_d = COLLECT;
        endcase

        push_c = bus.in_valid && !clear && (!full_c || pop_c);
        if (bus.in_valid && !clear && full_c && !pop_c) begin
            overflow_d = 1'b1;
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + ADDR_WIDTH'(1);
        end
        if (pop_c) begin
            rd_ptr_d = rd_ptr_q + ADDR_WIDTH'(1);
        end
        level_d = level_q + LVL_W'(push_c) - LVL_W'(pop_c);

        // Flush drops everything except the last word value, which is don't-care while invalid.
        if (clear) begin
            state_d      = COLLECT;
            rd_ptr_d     = '0;
            wr_ptr_d     = '0;
            level_d      = '0;
            idx_d        = 2'd0;
            word_valid_d = 1'b0;
            overflow_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= COLLECT;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            level_q      <= '0;
            idx_q        <= 2'd0;
            word_q       <= '0;
            word_valid_q <= 1'b0;
            overflow_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            level_q      <= level_d;
            idx_q        <= idx_d;
            word_q       <= word_d;
            word_valid_q <= word_valid_d;
            overflow_q   <= overflow_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and level.
    always_ff @(posedge clk) begin
        if (push_c) begin
            mem_q[wr_ptr_q] <= bus.in_data;
        end
    end

    assign bus.word       = word_q;
    assign bus.word_valid = word_valid_q;
    assign overflow       = overflow_q;
    assign level          = level_q;

endmodule

// File: tb/tb_rx_word_packer.sv
// Directed bench for rx_word_packer: byte streams, backpressure, overflow, clear and async reset.
module tb_rx_word_packer;

    localparam int unsigned DEPTH      = 16;
    localparam int unsigned ADDR_WIDTH = 4;

    logic clk;
    logic rst;
    logic clear;
    logic overflow;
    logic [ADDR_WIDTH:0] level;

    rx_word_packer_if bus ();

    rx_word_packer #(
        .DEPTH      (DEPTH),
        .ADDR_WIDTH (ADDR_WIDTH)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .clear    (clear),
        .bus      (bus),
        .overflow (overflow),
        .level    (level)
    );

    int checks;
    int fails;
    int wv_cycles;
    logic [31:0] got[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Advance one cycle; log the word accepted at the coming edge, then settle past the edge.
    task automatic tick();
        if (bus.word_valid && bus.word_ready) got.push_back(bus.word);
        if (bus.word_valid) wv_cycles++;
        @(posedge clk);
        #1;
    endtask

    task automatic push_byte(input logic [7:0] b);
        bus.in_valid = 1'b1;
        bus.in_data  = b;
        tick();
        bus.in_valid = 1'b0;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        clear = 1'b0;
        bus.in_valid = 1'b0;
        bus.in_data = 8'h00;
        bus.word_ready = 1'b0;
        #3;
        checks++;
        if (bus.word_valid !== 1'b0 || bus.word !== 32'h0) begin
            fails++;
            $display("FAIL reset_word: got valid=%b word=%h expected valid=0 word=00000000", bus.word_valid, bus.word);
        end
        checks++;
        if (level !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL reset_status: got level=%0d ovf=%b expected level=0 ovf=0", level, overflow);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_spaced_bytes();
        logic [7:0] bytes [4];
        bytes[0] = 8'h12; bytes[1] = 8'h34; bytes[2] = 8'h56; bytes[3] = 8'h78;
        got.delete();
        wv_cycles = 0;
        bus.word_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            push_byte(bytes[i]);
            idle(19);
        end
        checks++;
        if (got.size() !== 1 || got[0] !== 32'h12345678) begin
            fails++;
            $display("FAIL spaced_word: got count=%0d first=%h expected count=1 first=12345678", got.size(), (got.size() > 0) ? got[0] : 32'hx);
        end
        checks++;
        if (wv_cycles !== 1) begin
            fails++;
            $display("FAIL spaced_valid_cycles: got %0d expected 1", wv_cycles);
        end
    endtask

    task automatic test_back_to_back();
        got.delete();
        bus.word_ready = 1'b1;
        for (int i = 1; i <= 8; i++) push_byte(8'(i));
        idle(12);
        checks++;
        if (got.size() !== 2 || got[0] !== 32'h01020304 || got[1] !== 32'h05060708) begin
            fails++;
            $display("FAIL b2b_words: got count=%0d w0=%h w1=%h expected 2 01020304 05060708", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx, (got.size() > 1) ? got[1] : 32'hx);
        end
        checks++;
        if (overflow !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL b2b_status: got ovf=%b level=%0d expected ovf=0 level=0", overflow, level);
        end
    endtask

    task automatic test_overflow();
        logic [7:0] b;
        logic [31:0] exp_w;
        got.delete();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 20; i++) push_byte(8'(8'h20 + i));
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== 32'h20212223 || level !== 5'd16 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL full_hold: got valid=%b word=%h level=%0d ovf=%b expected 1 20212223 16 0",
                     bus.word_valid, bus.word, level, overflow);
        end
        push_byte(8'h99);
        checks++;
        if (overflow !== 1'b1 || level !== 5'd16) begin
            fails++;
            $display("FAIL overflow_set: got ovf=%b level=%0d expected ovf=1 level=16", overflow, level);
        end
        bus.word_ready = 1'b1;
        idle(40);
        checks++;
        if (got.size() !== 5) begin
            fails++;
            $display("FAIL overflow_drain_count: got %0d expected 5", got.size());
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            b = 8'(8'h20 + 4 * k);
            exp_w = {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
            checks++;
            if (got[k] !== exp_w) begin
                fails++;
                $display("FAIL overflow_drain_word%0d: got %h expected %h", k, got[k], exp_w);
            end
        end
        checks++;
        if (overflow !== 1'b1 || level !== 5'd0) begin
            fails++;
            $display("FAIL overflow_sticky: got ovf=%b level=%0d expected ovf=1 level=0", overflow, level);
        end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] b;
        logic [31:0] exp_w;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || level !== 5'd0 || bus.word_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_status: got ovf=%b level=%0d valid=%b expected 0 0 0", overflow, level, bus.word_valid);
        end
        got.delete();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 20; i++) push_byte(8'(8'h40 + i));
        checks++;
        if (level !== 5'd16) begin
            fails++;
            $display("FAIL fpp_full: got level=%0d expected 16", level);
        end
        bus.word_ready = 1'b1;
        tick();
        push_byte(8'h54);
        checks++;
        if (level !== 5'd16 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL fpp_push_pop: got level=%0d ovf=%b expected level=16 ovf=0", level, overflow);
        end
        idle(40);
        checks++;
        if (got.size() !== 5 || level !== 5'd0) begin
            fails++;
            $display("FAIL fpp_drain: got count=%0d level=%0d expected count=5 level=0", got.size(), level);
        end
        for (int k = 0; k < 5 && k < got.size(); k++) begin
            b = 8'(8'h40 + 4 * k);
            exp_w = {b, 8'(b + 8'd1), 8'(b + 8'd2), 8'(b + 8'd3)};
            checks++;
            if (got[k] !== exp_w) begin
                fails++;
                $display("FAIL fpp_word%0d: got %h expected %h", k, got[k], exp_w);
            end
        end
    endtask

    task automatic test_clear();
        bus.word_ready = 1'b0;
        clear = 1'b1;
        tick();
        clear = 1'b0;
        for (int i = 0; i < 20; i++) push_byte(8'(8'hC0 + i));
        // Clear with a coincident byte at a full FIFO must not raise overflow.
        clear = 1'b1;
        push_byte(8'hEE);
        clear = 1'b0;
        checks++;
        if (overflow !== 1'b0 || level !== 5'd0 || bus.word_valid !== 1'b0) begin
            fails++;
            $display("FAIL clear_coincident: got ovf=%b level=%0d valid=%b expected 0 0 0", overflow, level, bus.word_valid);
        end
        push_byte(8'hAA);
        push_byte(8'hBB);
        tick();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        got.delete();
        bus.word_ready = 1'b1;
        push_byte(8'h11);
        push_byte(8'h22);
        push_byte(8'h33);
        push_byte(8'h44);
        idle(10);
        checks++;
        if (got.size() !== 1 || got[0] !== 32'h11223344 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL clear_word: got count=%0d first=%h ovf=%b expected 1 11223344 0", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx, overflow);
        end
    endtask

    task automatic test_async_reset();
        bus.word_ready = 1'b1;
        push_byte(8'h61);
        push_byte(8'h62);
        tick();
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.word !== 32'h0 || bus.word_valid !== 1'b0 || level !== 5'd0 || overflow !== 1'b0) begin
            fails++;
            $display("FAIL rst_mid_word: got word=%h valid=%b level=%0d ovf=%b expected 00000000 0 0 0",
                     bus.word, bus.word_valid, level, overflow);
        end
        #1 rst = 1'b0;
        tick();
        bus.word_ready = 1'b0;
        for (int i = 0; i < 5; i++) push_byte(8'(8'h71 + i));
        idle(2);
        checks++;
        if (bus.word_valid !== 1'b1 || bus.word !== 32'h71727374 || level !== 5'd1) begin
            fails++;
            $display("FAIL hold_before_rst: got valid=%b word=%h level=%0d expected 1 71727374 1",
                     bus.word_valid, bus.word, level);
        end
        #2 rst = 1'b1;
        #1;
        checks++;
        if (bus.word !== 32'h0 || bus.word_valid !== 1'b0 || level !== 5'd0) begin
            fails++;
            $display("FAIL rst_mid_hold: got word=%h valid=%b level=%0d expected 00000000 0 0",
                     bus.word, bus.word_valid, level);
        end
        #1 rst = 1'b0;
        tick();
        got.delete();
        bus.word_ready = 1'b1;
        push_byte(8'h81);
        push_byte(8'h82);
        push_byte(8'h83);
        push_byte(8'h84);
        idle(10);
        checks++;
        if (got.size() !== 1 || got[0] !== 32'h81828384) begin
            fails++;
            $display("FAIL rst_fresh_word: got count=%0d first=%h expected 1 81828384", got.size(),
                     (got.size() > 0) ? got[0] : 32'hx);
        end
    endtask

    initial begin
        checks = 0;
        fails = 0;
        wv_cycles = 0;
        test_reset();
        test_spaced_bytes();
        test_back_to_back();
        test_overflow();
        test_full_push_pop();
        test_clear();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
